core_axi_mem_bridge: RTL and testbench

- Sits directly upstream of the AXI4 RAM model in the five-stage core.
- Converts the pipeline's single-outstanding load/store requests (`req_*`/`resp_*`) into that RAM's simplified AXI channel signals: AW/W/B for writes, AR plus 64-bit rdata for reads.
- Aligns the address and builds byte strobes from size and offset.
- Enforces a per-transaction timeout and returns one response per accepted request.

---
 rtl/core_axi_mem_bridge_if.sv | 39 +++
 rtl/core_axi_mem_bridge.sv | 148 ++++++++++++++
 tb/tb_core_axi_mem_bridge.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_axi_mem_bridge_if.sv
// Signal bundle between the core load/store port, the bridge and the AXI4 RAM model.
// The master view is the bridge itself; the slave view is the core plus RAM side.
interface core_axi_mem_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [31:0] io_awaddr;
    logic        io_awvalid;
    logic        io_awready;
    logic [31:0] io_araddr;
    logic        io_arvalid;
    logic        io_arready;
    logic [63:0] io_rdata;
    logic [63:0] io_wdata;
    logic [7:0]  io_wstrb;
    logic        io_wvalid;
    logic        io_wready;
    logic        io_bvalid;

    modport master (
        input  req_valid, req_addr, req_wen, req_size, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output io_awaddr, io_awvalid, io_araddr, io_arvalid, io_wdata, io_wstrb, io_wvalid,
        input  io_awready, io_arready, io_rdata, io_wready, io_bvalid
    );

    modport slave (
        output req_valid, req_addr, req_wen, req_size, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  io_awaddr, io_awvalid, io_araddr, io_arvalid, io_wdata, io_wstrb, io_wvalid,
        output io_awready, io_arready, io_rdata, io_wready, io_bvalid
    );
endinterface

// File: rtl/core_axi_mem_bridge.sv
// Single-outstanding load/store to simplified AXI bridge: aligns addresses, builds
// byte strobes, extracts load data by size/offset and aborts stalled bus phases.
module core_axi_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                   clock,
    input logic                   reset,
    core_axi_mem_bridge_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [1:0]  size_q;
    logic [63:0] wdata_q;
    logic [7:0]  cnt;
    logic        aw_done, w_done;
    logic [63:0] rdata_q;
    logic        err_q;

    logic [2:0]  off;
    logic        accept, aw_hs, w_hs, aw_all, w_all, expired, timed, err_nxt;
    logic [63:0] load_data;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] o);
        case (size)
            2'd1:    return o[0];
            2'd2:    return o[1:0] != 2'b00;
            2'd3:    return o != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] strb_of(input logic [1:0] size, input logic [2:0] o);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << o;
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    assign off       = addr_q[2:0];
    assign accept    = bus.req_valid && (state == IDLE);
    assign aw_hs     = (state == WR) && !aw_done && bus.io_awready;
    assign w_hs      = (state == WR) && !w_done && bus.io_wready;
    assign aw_all    = aw_done || aw_hs;
    assign w_all     = w_done || w_hs;
    assign timed     = (state == RD_ADDR) || (state == WR) || (state == WR_RESP);
    // Expiry is evaluated one count early so the bus valid is seen for exactly TIMEOUT_CYCLES cycles.
    assign expired   = (cnt == 8'(TIMEOUT_CYCLES - 1));
    assign load_data = (bus.io_rdata >> {off, 3'b000}) & size_mask(size_q);
    assign err_nxt   = (state == RD_DATA) ? 1'b0 :
                       (state == WR)      ? !(aw_all && w_all) :
                       (state == WR_RESP) ? !bus.io_bvalid : 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_misaligned(bus.req_size, bus.req_addr[2:0])) state_nxt = RESP;
                    else if (bus.req_wen)                              state_nxt = WR;
                    else                                               state_nxt = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (bus.io_arready)   state_nxt = RD_DATA;
                else if (expired)     state_nxt = RESP;
            end
            RD_DATA: state_nxt = RESP;
            WR: begin
                if (aw_all && w_all)  state_nxt = bus.io_bvalid ? RESP : WR_RESP;
                else if (expired)     state_nxt = RESP;
            end
            WR_RESP: begin
                if (bus.io_bvalid || expired) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = reset && (state == IDLE);
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        bus.io_arvalid = (state == RD_ADDR);
        bus.io_awvalid = (state == WR) && !aw_done;
        bus.io_wvalid  = (state == WR) && !w_done;
        bus.io_awaddr  = {addr_q[31:3], 3'b000};
        bus.io_araddr  = {addr_q[31:3], 3'b000};
        bus.io_wdata   = wdata_q << {off, 3'b000};
        bus.io_wstrb   = wen_q ? strb_of(size_q, off) : 8'h00;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wen_q   <= bus.req_wen;
                size_q  <= bus.req_size;
                wdata_q <= bus.req_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (state_nxt != state) cnt <= '0;
            else if (timed)         cnt <= cnt + 8'd1;
            if (state != RESP && state_nxt == RESP) begin
                rdata_q <= (state == RD_DATA) ? load_data : 64'd0;
                err_q   <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_core_axi_mem_bridge.sv
// Directed bench for core_axi_mem_bridge: loads, stores, misalignment, timeout and reset.
module tb_core_axi_mem_bridge;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    core_axi_mem_bridge_if bus();

    core_axi_mem_bridge #(.TIMEOUT_CYCLES(255)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [63:0] d);
        bus.req_addr  = a;
        bus.req_wen   = w;
        bus.req_size  = s;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        checks++; if ({bus.io_arvalid, bus.io_awvalid, bus.io_wvalid, bus.resp_valid} !== 4'b0000) begin
            errors++; $display("FAIL rst_valids: got %b want 0000", {bus.io_arvalid, bus.io_awvalid, bus.io_wvalid, bus.resp_valid}); end
        checks++; if ({bus.io_awaddr, bus.io_araddr, bus.io_wstrb} !== 72'd0) begin
            errors++; $display("FAIL rst_addr_strb: aw %h ar %h strb %h want 0", bus.io_awaddr, bus.io_araddr, bus.io_wstrb); end
        checks++; if ({bus.resp_rdata, bus.io_wdata} !== 128'd0) begin
            errors++; $display("FAIL rst_data: rdata %h wdata %h want 0", bus.resp_rdata, bus.io_wdata); end
        reset = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
        tick();
    endtask

    task automatic test_load_dword();
        issue(32'h8000_0010, 1'b0, 2'd3, 64'd0);
        checks++; if (bus.io_arvalid !== 1'b1 || bus.io_araddr !== 32'h8000_0010) begin
            errors++; $display("FAIL ld_ar_t1: arvalid %b araddr %h want 1 80000010", bus.io_arvalid, bus.io_araddr); end
        bus.io_arready = 1'b1;
        tick();
        bus.io_arready = 1'b0;
        bus.io_rdata   = 64'h1122_3344_5566_7788;
        checks++; if (bus.io_arvalid !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL ld_t2: arvalid %b resp_valid %b want 0 0", bus.io_arvalid, bus.resp_valid); end
        tick();
        bus.io_rdata = 64'd0;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 64'h1122_3344_5566_7788) begin
            errors++; $display("FAIL ld_resp_t3: valid %b err %b rdata %h want 1 0 1122334455667788", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        tick();
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL ld_t4: resp_valid %b req_ready %b want 0 1", bus.resp_valid, bus.req_ready); end
    endtask

    task automatic test_misaligned();
        issue(32'h8000_0003, 1'b0, 2'd1, 64'd0);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 64'd0) begin
            errors++; $display("FAIL mis_resp_t1: valid %b err %b rdata %h want 1 1 0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        checks++; if ({bus.io_arvalid, bus.io_awvalid, bus.io_wvalid} !== 3'b000) begin
            errors++; $display("FAIL mis_bus: got %b want 000", {bus.io_arvalid, bus.io_awvalid, bus.io_wvalid}); end
        tick();
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.io_arvalid !== 1'b0) begin
            errors++; $display("FAIL mis_t2: resp %b ready %b arvalid %b want 0 1 0", bus.resp_valid, bus.req_ready, bus.io_arvalid); end
    endtask

    task automatic test_store_byte();
        issue(32'h8000_0005, 1'b1, 2'd0, 64'h0000_0000_0000_00AB);
        checks++; if ({bus.io_awvalid, bus.io_wvalid} !== 2'b11 || bus.io_awaddr !== 32'h8000_0000) begin
            errors++; $display("FAIL stb_aw_t1: valids %b awaddr %h want 11 80000000", {bus.io_awvalid, bus.io_wvalid}, bus.io_awaddr); end
        checks++; if (bus.io_wstrb !== 8'h20 || bus.io_wdata !== 64'h0000_AB00_0000_0000) begin
            errors++; $display("FAIL stb_w_t1: wstrb %h wdata %h want 20 0000ab0000000000", bus.io_wstrb, bus.io_wdata); end
        bus.io_awready = 1'b1;
        bus.io_wready  = 1'b1;
        tick();
        bus.io_awready = 1'b0;
        bus.io_wready  = 1'b0;
        checks++; if ({bus.io_awvalid, bus.io_wvalid, bus.resp_valid} !== 3'b000) begin
            errors++; $display("FAIL stb_t2: got %b want 000", {bus.io_awvalid, bus.io_wvalid, bus.resp_valid}); end
        bus.io_bvalid = 1'b1;
        tick();
        bus.io_bvalid = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 64'd0) begin
            errors++; $display("FAIL stb_resp_t3: valid %b err %b rdata %h want 1 0 0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        tick();
    endtask

    task automatic test_store_delayed();
        int aw_cnt = 0;
        int w_cnt = 0;
        int resp_cnt = 0;
        int resp_cyc = -1;
        logic resp_e = 1'b1;
        issue(32'h8000_000C, 1'b1, 2'd2, 64'h0000_0000_DEAD_BEEF);
        checks++; if (bus.io_awaddr !== 32'h8000_0008 || bus.io_wstrb !== 8'hF0 || bus.io_wdata !== 64'hDEAD_BEEF_0000_0000) begin
            errors++; $display("FAIL stw_t1: awaddr %h wstrb %h wdata %h want 80000008 f0 deadbeef00000000", bus.io_awaddr, bus.io_wstrb, bus.io_wdata); end
        for (int cyc = 1; cyc <= 10; cyc++) begin
            bus.io_wready  = (cyc == 1);
            bus.io_awready = (cyc == 4);
            bus.io_bvalid  = (cyc == 2) || (cyc == 5);
            aw_cnt += int'(bus.io_awvalid);
            w_cnt  += int'(bus.io_wvalid);
            if (bus.resp_valid === 1'b1) begin
                resp_cnt++;
                resp_cyc = cyc;
                resp_e   = bus.resp_err;
            end
            tick();
        end
        bus.io_wready  = 1'b0;
        bus.io_awready = 1'b0;
        bus.io_bvalid  = 1'b0;
        checks++; if (aw_cnt !== 4) begin errors++; $display("FAIL stw_aw_len: got %0d want 4", aw_cnt); end
        checks++; if (w_cnt !== 1)  begin errors++; $display("FAIL stw_w_len: got %0d want 1", w_cnt); end
        checks++; if (resp_cnt !== 1 || resp_cyc !== 6 || resp_e !== 1'b0) begin
            errors++; $display("FAIL stw_resp: count %0d cycle %0d err %b want 1 6 0", resp_cnt, resp_cyc, resp_e); end
    endtask

    task automatic test_load_sizes();
        logic [31:0] a;
        logic [1:0]  s;
        logic [63:0] exp;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin a = 32'h8000_0004; s = 2'd2; exp = 64'h0000_0000_1122_3344; end
                1:       begin a = 32'h8000_0006; s = 2'd0; exp = 64'h0000_0000_0000_0022; end
                default: begin a = 32'h8000_0002; s = 2'd1; exp = 64'h0000_0000_0000_5566; end
            endcase
            issue(a, 1'b0, s, 64'd0);
            bus.io_rdata   = 64'hFFFF_FFFF_FFFF_FFFF;
            bus.io_arready = 1'b1;
            checks++; if (bus.io_araddr !== 32'h8000_0000) begin
                errors++; $display("FAIL ldsz%0d_araddr: got %h want 80000000", i, bus.io_araddr); end
            tick();
            bus.io_arready = 1'b0;
            bus.io_rdata   = 64'h1122_3344_5566_7788;
            tick();
            bus.io_rdata = 64'd0;
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== exp) begin
                errors++; $display("FAIL ldsz%0d_resp: valid %b err %b rdata %h want 1 0 %h", i, bus.resp_valid, bus.resp_err, bus.resp_rdata, exp); end
            tick();
        end
    endtask

    task automatic test_timeout();
        int ar_cnt = 0;
        int n;
        issue(32'h8000_0020, 1'b0, 2'd3, 64'd0);
        bus.io_arready = 1'b0;
        for (n = 0; n < 300 && bus.resp_valid !== 1'b1; n++) begin
            ar_cnt += int'(bus.io_arvalid);
            tick();
        end
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL to_no_resp: no response within %0d cycles", n); end
        checks++; if (ar_cnt !== 255) begin errors++; $display("FAIL to_ar_len: got %0d want 255", ar_cnt); end
        checks++; if (bus.resp_err !== 1'b1 || bus.resp_rdata !== 64'd0 || bus.io_arvalid !== 1'b0) begin
            errors++; $display("FAIL to_resp: err %b rdata %h arvalid %b want 1 0 0", bus.resp_err, bus.resp_rdata, bus.io_arvalid); end
        tick();
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL to_ready: ready %b resp %b want 1 0", bus.req_ready, bus.resp_valid); end
    endtask

    task automatic test_reset_mid();
        int resp_cnt = 0;
        issue(32'h8000_0040, 1'b1, 2'd3, 64'h0123_4567_89AB_CDEF);
        bus.io_awready = 1'b1;
        bus.io_wready  = 1'b1;
        tick();
        bus.io_awready = 1'b0;
        bus.io_wready  = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if ({bus.io_arvalid, bus.io_awvalid, bus.io_wvalid, bus.resp_valid, bus.req_ready} !== 5'b00000) begin
            errors++; $display("FAIL rmid_valids: got %b want 00000", {bus.io_arvalid, bus.io_awvalid, bus.io_wvalid, bus.resp_valid, bus.req_ready}); end
        checks++; if (bus.io_awaddr !== 32'd0 || bus.io_wdata !== 64'd0 || bus.io_wstrb !== 8'd0) begin
            errors++; $display("FAIL rmid_regs: awaddr %h wdata %h wstrb %h want 0", bus.io_awaddr, bus.io_wdata, bus.io_wstrb); end
        tick();
        reset = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", bus.req_ready); end
        tick();
        bus.io_bvalid = 1'b1;
        tick();
        bus.io_bvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            resp_cnt += int'(bus.resp_valid);
            tick();
        end
        checks++; if (resp_cnt !== 0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_late_b: responses %0d ready %b want 0 1", resp_cnt, bus.req_ready); end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wen    = 1'b0;
        bus.req_size   = '0;
        bus.req_wdata  = '0;
        bus.io_awready = 1'b0;
        bus.io_arready = 1'b0;
        bus.io_rdata   = '0;
        bus.io_wready  = 1'b0;
        bus.io_bvalid  = 1'b0;
        test_reset();
        test_load_dword();
        test_misaligned();
        test_store_byte();
        test_store_delayed();
        test_load_sizes();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
